mux_8_1_scanner: RTL and testbench
==================================

Name: mux_8_1_scanner

Overview:
- Sequential scan controller that sits directly around mux_8_1.
- Drives the mux select (seleksioni) through all 8 positions, samples the mux output (dalja) once per clock, and assembles the 8 sampled bits into a parallel byte.
- The byte, plus its parity, goes to downstream logic through a valid/ready handshake.
- Turns the combinational 8:1 selector into a timed parallel capture of data1..data8.

Parameters:
- SCAN_DOWN, 0, scan order. 0 = select 0→7; 1 = select 7→0. Bit placement in data_out is the same for both orders.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request one scan; honoured in IDLE, or in VALID together with data_ready.
- abort  input  1  cancels a scan in progress.
- dalja  input  1  mux_8_1 output being sampled.
- seleksioni  output  3  select driven to mux_8_1; registered.
- busy  output  1  high while in SCAN.
- data_out  output  8  assembled byte; data_out[i] = dalja sampled while seleksioni == i.
- data_valid  output  1  data_out/parity hold a complete, unconsumed result.
- data_ready  input  1  downstream accepts the result.
- parity  output  1  XOR of all data_out bits (even parity), registered with data_out.

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - reset is synchronous, active-high, and overrides every other input.
  - Reset values: seleksioni = 3'b000 (3'b111 if SCAN_DOWN=1), busy = 0, data_out = 8'h00, data_valid = 0, parity = 0, state = IDLE.
- States are IDLE, SCAN and VALID.
- IDLE:
  - busy = 0, data_valid = 0, seleksioni at the first index.
  - start = 1 at edge E0 → SCAN, with index = first index (0, or 7 if SCAN_DOWN=1).
- SCAN:
  - busy = 1 and seleksioni = current index, driven from the register (no combinational path from start).
  - At each edge: data_out[index] <= dalja; index steps by ±1 with no wrap inside a scan.
  - Bit k of the scan is sampled at edge E(k+1).
  - After the 8th sample (edge E8): data_valid <= 1, parity <= XOR of the final byte, busy <= 0, state → VALID, and seleksioni is reloaded to the first index.
  - Latency: data_valid is visible 8 clocks after the start edge.
  - dalja must be stable for the whole cycle in which seleksioni points at a bit. mux_8_1 is purely combinational, so one cycle is enough.
  - start is ignored during SCAN.
- abort:
  - Honoured only in SCAN; → IDLE at the next edge, and no sample is taken on that edge.
  - data_out and parity revert to their pre-scan values: partial samples are written to a shadow register, and data_out is updated only at E8.
  - data_valid stays 0. abort has no effect in IDLE or VALID.
- VALID:
  - data_out, parity and data_valid are held until data_ready = 1 at an edge.
  - Acceptance edge with start = 0 → IDLE, data_valid <= 0.
  - Acceptance edge with start = 1 → SCAN directly (back-to-back). data_valid <= 0 and the new scan begins without an idle cycle.
  - start without data_ready in VALID is ignored (no overrun, no queueing).
- Simultaneous events:
  - reset dominates abort.
  - abort dominates the 8th-sample completion: abort on the E8 edge means no result.
  - data_ready in IDLE/SCAN is ignored.
- Mid-operation reset returns every output to its reset value within the same edge.

Test Plan:
- Basic capture: reset; data1..8 = 1,0,1,1,0,0,1,0 via mux_8_1; pulse start → seleksioni 0,1,…,7 on consecutive cycles; data_valid high 8 clocks after start with data_out = 8'h4D, parity = 0.
- Descending scan: SCAN_DOWN=1, same inputs → seleksioni 7,6,…,0; data_out = 8'h4D again; parity = 0.
- Handshake hold and back-to-back:
  - Hold data_ready = 0 for 5 cycles → data_valid and data_out are stable and a start pulse is ignored.
  - Then data_ready = 1 with start = 1 → next cycle busy = 1 and seleksioni = 0, with no idle gap.
- Abort:
  - After a completed result 8'hFF, start a new scan with all inputs 0.
  - Assert abort when seleksioni = 4 → IDLE next cycle; data_out still 8'hFF, data_valid = 0.
  - abort coinciding with the 8th sample → no data_valid.
- Reset mid-scan: assert reset with seleksioni = 5 → next cycle all outputs at reset values; a subsequent start yields a correct byte.
- Parity sweep: inputs 8'h01, 8'h03, 8'hFF, 8'h80 → parity 1, 0, 0, 1 respectively.

Source files
------------

// File: rtl/mux_8_1_scanner_if.sv
// mux_8_1_scanner_if: scan-controller bus (mux select/sample, result handshake)
interface mux_8_1_scanner_if;
  logic       start;
  logic       abort;
  logic       dalja;
  logic       data_ready;
  logic [2:0] seleksioni;
  logic       busy;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity;
  modport master (
    output start, abort, dalja, data_ready,
    input  seleksioni, busy, data_out, data_valid, parity
  );
  modport slave (
    input  start, abort, dalja, data_ready,
    output seleksioni, busy, data_out, data_valid, parity
  );
endinterface

// File: rtl/mux_8_1_scanner.sv
// mux_8_1_scanner: steps the mux_8_1 select, samples dalja and assembles a byte with parity
module mux_8_1_scanner #(
  parameter bit SCAN_DOWN = 1'b0
) (
  input logic               clk,
  input logic               reset,
  mux_8_1_scanner_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SCAN, VALID} state_t;
  localparam logic [2:0] FIRST = SCAN_DOWN ? 3'd7 : 3'd0;
  localparam logic [2:0] LAST = SCAN_DOWN ? 3'd0 : 3'd7;
  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] data_q, data_d;
  logic       parity_q, parity_d;
  logic [7:0] sampled;
  always_comb begin
    sampled = shadow_q;
    sampled[idx_q] = bus.dalja;
  end
  // partial samples live in shadow_q so an abort leaves the published byte untouched
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    shadow_d = shadow_q;
    data_d = data_q;
    parity_d = parity_q;
    case (state_q)
      IDLE: state_d = bus.start ? SCAN : IDLE;
      SCAN: begin
        if (bus.abort) begin
          state_d = IDLE;
          idx_d = FIRST;
        end else begin
          shadow_d = sampled;
          idx_d = SCAN_DOWN ? idx_q - 3'd1 : idx_q + 3'd1;
          if (idx_q == LAST) begin
            state_d = VALID;
            idx_d = FIRST;
            data_d = sampled;
            parity_d = ^sampled;
          end
        end
      end
      VALID: state_d = bus.data_ready ? (bus.start ? SCAN : IDLE) : VALID;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= FIRST;
      shadow_q <= '0;
      data_q <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      shadow_q <= shadow_d;
      data_q <= data_d;
      parity_q <= parity_d;
    end
  end
  assign bus.seleksioni = idx_q;
  assign bus.busy = state_q == SCAN;
  assign bus.data_valid = state_q == VALID;
  assign bus.data_out = data_q;
  assign bus.parity = parity_q;
endmodule

// File: tb/tb_mux_8_1_scanner.sv
// tb_mux_8_1_scanner: scoreboard bench driving ascending and descending scanners side by side
module tb_mux_8_1_scanner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, abort = 1'b0, ready = 1'b0;
  logic [7:0] din = 8'h00;
  int checks = 0, errors = 0;
  logic [8:0] qu[$], qd[$];
  always #5 clk = ~clk;
  mux_8_1_scanner_if iu ();
  mux_8_1_scanner_if id ();
  mux_8_1_scanner #(.SCAN_DOWN(1'b0)) du (.clk(clk), .reset(reset), .bus(iu.slave));
  mux_8_1_scanner #(.SCAN_DOWN(1'b1)) dd (.clk(clk), .reset(reset), .bus(id.slave));
  assign iu.start = start;
  assign id.start = start;
  assign iu.abort = abort;
  assign id.abort = abort;
  assign iu.data_ready = ready;
  assign id.data_ready = ready;
  assign iu.dalja = din[iu.seleksioni];
  assign id.dalja = din[id.seleksioni];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_byte(input logic [7:0] v);
    qu.push_back({v, ^v});
    qd.push_back({v, ^v});
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sel_u"}, iu.seleksioni, 3'd0);
    chk({tag, "_sel_d"}, id.seleksioni, 3'd7);
    chk({tag, "_busy"}, {iu.busy, id.busy}, 2'b00);
    chk({tag, "_valid"}, {iu.data_valid, id.data_valid}, 2'b00);
    chk({tag, "_data"}, {iu.data_out, id.data_out}, 16'h0000);
    chk({tag, "_parity"}, {iu.parity, id.parity}, 2'b00);
  endtask
  task automatic run_scan(input logic [7:0] v);
    din = v;
    expect_byte(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(8);
  endtask
  task automatic accept();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!reset && ready) begin
      if (iu.data_valid) begin
        if (qu.size() == 0) chk("u_spurious_result", 1, 0);
        else chk("u_result", {iu.data_out, iu.parity}, qu.pop_front());
      end
      if (id.data_valid) begin
        if (qd.size() == 0) chk("d_spurious_result", 1, 0);
        else chk("d_result", {id.data_out, id.parity}, qd.pop_front());
      end
    end
  end
  initial begin
    logic [7:0] pv[4];
    logic [3:0] pexp;
    bit ab, hit;
    int ak;
    tick(2);
    chk_reset_vals("reset");
    reset = 1'b0;
    tick();
    // basic capture: data1..data8 = 1,0,1,1,0,0,1,0
    din = 8'b0100_1101;
    expect_byte(din);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("scan_sel_u", iu.seleksioni, k);
      chk("scan_sel_d", id.seleksioni, 7 - k);
      chk("scan_busy", {iu.busy, id.busy, iu.data_valid}, 3'b110);
      tick();
    end
    chk("basic_valid", {iu.data_valid, id.data_valid, iu.busy}, 3'b110);
    chk("basic_data", {iu.data_out, id.data_out}, 16'h4D4D);
    chk("basic_parity", {iu.parity, id.parity}, 2'b00);
    chk("basic_sel_reload", {iu.seleksioni, id.seleksioni}, 6'o07);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      tick();
      chk("hold", {iu.data_valid, iu.busy, iu.data_out, id.data_out}, {2'b10, 16'h4D4D});
    end
    din = 8'h3C;
    expect_byte(din);
    ready = 1'b1;
    start = 1'b1;
    tick();
    ready = 1'b0;
    start = 1'b0;
    chk("b2b_busy", {iu.busy, id.busy, iu.data_valid}, 3'b110);
    chk("b2b_sel", {iu.seleksioni, id.seleksioni}, 6'o07);
    tick(7);
    chk("b2b_not_yet", iu.data_valid, 1'b0);
    tick();
    chk("b2b_valid", {iu.data_valid, id.data_valid}, 2'b11);
    accept();
    run_scan(8'hFF);
    accept();
    din = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(4);
    chk("abort_at_sel4", iu.seleksioni, 3'd4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", {iu.busy, id.busy, iu.data_valid, id.data_valid}, 4'b0000);
    chk("abort_keeps_data", {iu.data_out, id.data_out, iu.parity}, {16'hFFFF, 1'b0});
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_e8_no_valid", {iu.data_valid, id.data_valid, iu.busy}, 3'b000);
    chk("abort_e8_keeps_data", {iu.data_out, id.data_out}, 16'hFFFF);
    tick(3);
    chk("abort_e8_still_idle", {iu.data_valid, iu.busy}, 2'b00);
    din = 8'hA5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(5);
    chk("reset_at_sel5", iu.seleksioni, 3'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals("midreset");
    run_scan($urandom);
    accept();
    pv = '{8'h01, 8'h03, 8'hFF, 8'h80};
    pexp = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      run_scan(pv[i]);
      chk("parity_sweep", {iu.parity, id.parity}, {2{pexp[i]}});
      accept();
    end
    for (int it = 0; it < 60; it++) begin
      din = $urandom;
      ab = ($urandom_range(3) == 0);
      ak = $urandom_range(7);
      hit = 1'b0;
      if (!ab) expect_byte(din);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 8 && !hit; k++) begin
        abort = ab && (k == ak);
        hit = abort;
        ready = $urandom_range(1);
        tick();
      end
      abort = 1'b0;
      ready = 1'b0;
      if (ab) chk("rand_abort_idle", {iu.busy, iu.data_valid, id.data_valid}, 3'b000);
      else begin
        chk("rand_valid", {iu.data_valid, id.data_valid}, 2'b11);
        for (int w = $urandom_range(3); w > 0; w--) begin
          start = $urandom_range(1);
          tick();
          start = 1'b0;
        end
        accept();
      end
    end
    tick(3);
    chk("u_queue_drained", qu.size(), 0);
    chk("d_queue_drained", qd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
